seq_mult: RTL and testbench



---
 rtl/seq_mult_pkg.sv | 17 +
 rtl/seq_mult_acc_shift_reg.sv | 72 +++++++
 rtl/seq_mult.sv | 98 +++++++++
 tb/tb_seq_mult.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/seq_mult_pkg.sv
// Shared types and helpers for the sequential shift-add / Booth multiplier.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package seq_mult_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Iteration counter width: must be able to hold the value N itself.
   function automatic int cnt_width(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/seq_mult_acc_shift_reg.sv
// Add-then-shift register holding A (N+1 bits), Q (N bits) and the Booth history bit Qm1.
// Latency: one iteration per i_step edge; i_load clears A/Qm1 and loads Q in one edge.
// Backpressure: none; it follows i_load/i_step unconditionally.
// Ports: clock, reset (sync, active-high), i_load, i_step, i_mode (1 = Booth/signed),
//        i_m (multiplicand), i_qin (multiplier), o_aq ({A[N-1:0],Q} after the current step).
module acc_shift_reg
   import seq_mult_pkg::*;
#(
   parameter int N = 8
) (
   input  logic           clock,
   input  logic           reset,
   input  logic           i_load,
   input  logic           i_step,
   input  logic           i_mode,
   input  logic [N-1:0]   i_m,
   input  logic [N-1:0]   i_qin,
   output logic [2*N-1:0] o_aq
);

   logic [N:0]   r_a;
   logic [N-1:0] r_q;
   logic         r_qm1;

   logic [N:0]   w_m_ext;
   logic [N:0]   w_sum;
   logic [N:0]   w_a_nxt;
   logic [N-1:0] w_q_nxt;

   // In signed mode the multiplicand is sign-extended into the N+1-bit adder so
   // that M = -2^(N-1) can be subtracted without overflow.
   assign w_m_ext = i_mode ? {i_m[N-1], i_m} : {1'b0, i_m};

   always_comb begin
      w_sum = r_a;
      if (i_mode) begin
         case ({r_q[0], r_qm1})
            2'b01:   w_sum = r_a + w_m_ext;
            2'b10:   w_sum = r_a - w_m_ext;
            default: w_sum = r_a;
         endcase
      end else if (r_q[0]) begin
         w_sum = r_a + w_m_ext;
      end
   end

   // Right shift of {A,Q}: unsigned inserts 0 (the carry has already landed in
   // A[N]), signed replicates A[N].
   assign w_a_nxt = {(i_mode ? w_sum[N] : 1'b0), w_sum[N:1]};
   assign w_q_nxt = {w_sum[0], r_q[N-1:1]};

   // Post-step view, so the controller can capture the product on the same
   // edge as the final iteration.
   assign o_aq = {w_a_nxt[N-1:0], w_q_nxt};

   always_ff @(posedge clock) begin
      if (reset) begin
         r_a   <= '0;
         r_q   <= '0;
         r_qm1 <= 1'b0;
      end else if (i_load) begin
         r_a   <= '0;
         r_q   <= i_qin;
         r_qm1 <= 1'b0;
      end else if (i_step) begin
         r_a   <= w_a_nxt;
         r_q   <= w_q_nxt;
         r_qm1 <= r_q[0];
      end
   end

endmodule

// File: rtl/seq_mult.sv
// Multi-cycle N x N multiplier, unsigned shift-add or signed radix-2 Booth, selected per operation.
// Latency: start sampled at edge k -> busy for N cycles -> done pulse and product valid after edge k+N.
// Backpressure: start is ignored while busy; product is held until the next completion.
// Ports: clock, reset (sync, active-high), start, signed_mode, multiplicand, multiplier,
//        busy, done, product (2N bits).
module seq_mult
   import seq_mult_pkg::*;
#(
   parameter int N = 8
) (
   input  logic           clock,
   input  logic           reset,
   input  logic           start,
   input  logic           signed_mode,
   input  logic [N-1:0]   multiplicand,
   input  logic [N-1:0]   multiplier,
   output logic           busy,
   output logic           done,
   output logic [2*N-1:0] product
);

   localparam int CW = cnt_width(N);

   state_t           r_state;
   logic [CW-1:0]    r_count;
   logic [N-1:0]     r_m;
   logic             r_mode;
   logic             r_busy;
   logic             r_done;
   logic [2*N-1:0]   r_product;

   logic             w_load;
   logic             w_step;
   logic [2*N-1:0]   w_aq;

   // A new operation is accepted from IDLE or DONE (back-to-back).
   assign w_load = (r_state != RUN) && start;
   assign w_step = (r_state == RUN);

   acc_shift_reg #(.N(N)) u_acc (
      .clock  (clock),
      .reset  (reset),
      .i_load (w_load),
      .i_step (w_step),
      .i_mode (r_mode),
      .i_m    (r_m),
      .i_qin  (multiplier),
      .o_aq   (w_aq)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state   <= IDLE;
         r_count   <= '0;
         r_m       <= '0;
         r_mode    <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_product <= '0;
      end else begin
         case (r_state)
            IDLE, DONE: begin
               r_done <= 1'b0;
               if (start) begin
                  r_m     <= multiplicand;
                  r_mode  <= signed_mode;
                  r_count <= CW'(N);
                  r_state <= RUN;
                  r_busy  <= 1'b1;
               end else begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end
            end
            RUN: begin
               r_count <= r_count - CW'(1);
               // Last iteration happens on this edge; capture its result directly.
               if (r_count == CW'(1)) begin
                  r_product <= w_aq;
                  r_state   <= DONE;
                  r_busy    <= 1'b0;
                  r_done    <= 1'b1;
               end
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   assign busy    = r_busy;
   assign done    = r_done;
   assign product = r_product;

endmodule

// File: tb/tb_seq_mult.sv
module tb_seq_mult;

   localparam int N = 8;

   logic           clock;
   logic           reset;
   logic           start;
   logic           signed_mode;
   logic [N-1:0]   multiplicand;
   logic [N-1:0]   multiplier;
   logic           busy;
   logic           done;
   logic [2*N-1:0] product;

   int             n_vec;
   int             n_err;
   logic [2*N-1:0] exp_q[$];
   logic [2*N-1:0] last_prod;

   seq_mult #(.N(N)) dut (
      .clock        (clock),
      .reset        (reset),
      .start        (start),
      .signed_mode  (signed_mode),
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
      .busy         (busy),
      .done         (done),
      .product      (product)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [2*N-1:0] model(input logic [N-1:0] m, input logic [N-1:0] q,
                                            input logic sm);
      int a;
      int b;
      a = sm ? int'($signed(m)) : int'(m);
      b = sm ? int'($signed(q)) : int'(q);
      return (2*N)'(a * b);
   endfunction

   // Drive one start pulse (sampled at the next edge) and check busy rises.
   task automatic start_op(input string tag, input logic [N-1:0] m, input logic [N-1:0] q,
                           input logic sm, input bit push);
      multiplicand = m;
      multiplier   = q;
      signed_mode  = sm;
      start        = 1'b1;
      if (push) exp_q.push_back(model(m, q, sm));
      @(posedge clock); #1;
      start = 1'b0;
      check({tag, "_busy_rise"}, 32'(busy), 32'd1);
   endtask

   // Wait (bounded) for done, checking latency, busy length, product stability
   // during RUN, and the product itself. Optionally injects a start mid-RUN.
   task automatic wait_done(input string tag, input bit inj);
      int busy_cnt;
      int lat;
      bit unstable;
      logic [2*N-1:0] exp;
      busy_cnt = 1;
      lat      = 0;
      unstable = 1'b0;
      for (int i = 1; i <= N + 4; i++) begin
         if (inj && i == 3) begin
            start        = 1'b1;
            multiplicand = 8'h55;
            multiplier   = 8'h33;
            signed_mode  = ~signed_mode;
         end else begin
            start = 1'b0;
         end
         @(posedge clock); #1;
         if (done) begin
            lat = i;
            break;
         end
         if (busy) busy_cnt++;
         if (product !== last_prod) unstable = 1'b1;
      end
      start = 1'b0;
      check({tag, "_latency"}, 32'(lat), 32'(N));
      check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(N));
      check({tag, "_held_in_run"}, 32'(unstable), 32'd0);
      check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      check({tag, "_product"}, 32'(product), 32'(exp));
      last_prod = exp;
   endtask

   // Cycle after done with no new start: done drops, product holds.
   task automatic check_after(input string tag);
      @(posedge clock); #1;
      check({tag, "_done_pulse"}, 32'(done), 32'd0);
      check({tag, "_hold"}, 32'(product), 32'(last_prod));
   endtask

   initial begin
      int done_seen;
      n_vec        = 0;
      n_err        = 0;
      last_prod    = '0;
      reset        = 1'b1;
      start        = 1'b0;
      signed_mode  = 1'b0;
      multiplicand = '0;
      multiplier   = '0;
      repeat (2) @(posedge clock);
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_product", 32'(product), 32'd0);
      reset = 1'b0;
      @(posedge clock); #1;

      start_op("u13x11", 8'd13, 8'd11, 1'b0, 1'b1);
      wait_done("u13x11", 1'b0);
      check("u13x11_lit", 32'(product), 32'h008F);
      check_after("u13x11");

      start_op("umax", 8'hFF, 8'hFF, 1'b0, 1'b1);
      wait_done("umax", 1'b0);
      check("umax_lit", 32'(product), 32'hFE01);
      check_after("umax");

      start_op("s_m3x5", 8'hFD, 8'h05, 1'b1, 1'b1);
      wait_done("s_m3x5", 1'b0);
      check("s_m3x5_lit", 32'(product), 32'hFFF1);

      start_op("s_minmin", 8'h80, 8'h80, 1'b1, 1'b1);
      wait_done("s_minmin", 1'b0);
      check("s_minmin_lit", 32'(product), 32'h4000);

      start_op("s_minmax", 8'h80, 8'h7F, 1'b1, 1'b1);
      wait_done("s_minmax", 1'b0);
      check("s_minmax_lit", 32'(product), 32'hC080);

      start_op("u_zero", 8'h00, 8'hB7, 1'b0, 1'b1);
      wait_done("u_zero", 1'b0);

      start_op("s_zero", 8'h80, 8'h00, 1'b1, 1'b1);
      wait_done("s_zero", 1'b0);

      start_op("s_mix", 8'h9C, 8'h25, 1'b1, 1'b1);
      wait_done("s_mix", 1'b0);
      check_after("s_mix");

      // Start mid-RUN is ignored; then back-to-back start in the DONE cycle.
      start_op("inj", 8'd200, 8'd3, 1'b0, 1'b1);
      wait_done("inj", 1'b1);
      start_op("b2b", 8'd7, 8'd6, 1'b0, 1'b1);
      wait_done("b2b", 1'b0);
      check("b2b_lit", 32'(product), 32'h002A);
      check_after("b2b");

      // Reset during cycle 4 of RUN aborts the operation with no done.
      start_op("abort", 8'd99, 8'd77, 1'b0, 1'b0);
      repeat (3) @(posedge clock);
      #1;
      reset = 1'b1;
      @(posedge clock); #1;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_product", 32'(product), 32'd0);
      reset = 1'b0;
      done_seen = 0;
      for (int i = 0; i < 2 * N; i++) begin
         @(posedge clock); #1;
         if (done || busy) done_seen++;
      end
      check("abort_no_done", 32'(done_seen), 32'd0);
      check("queue_empty", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
